// File: rtl/spi_slave_ctrl.sv
// SPI-style frame receiver: DATA_W+2 bit frames (2-bit command + payload) to memory,
// with a read-data phase that streams one memory word back on miso.
//
// state     | meaning
// IDLE      | waiting for ss_n low
// CHK_CMD   | sampling frame MSB to pick write / read-address / read-data route
// WRITE     | shifting a write frame, then parked until ss_n high
// READ_ADD  | shifting a read-address frame, then parked until ss_n high
// READ_DATA | shifting a read-data frame, waiting for tx_valid, bursting miso
module spi_slave_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [DATA_W:0]   rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              frame_done;
  logic              bursting;
  logic              burst_done;
  logic              rd_addr_seen;

  logic shift_en;
  logic last_bit;
  logic tx_load;
  logic burst_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    last_bit  = 1'b0;
    tx_load   = 1'b0;
    burst_end = 1'b0;
    if (state != IDLE && ss_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!ss_n) state_nxt = CHK_CMD;
        end
        CHK_CMD: begin
          if (!mosi)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shift_en = 1'b1;
            last_bit = (bit_cnt == '0);
          end else if (state == READ_DATA) begin
            // tx_valid only matters in the gap between frame end and burst start
            if (bursting)                    burst_end = (burst_cnt == CNT_W'(1));
            else if (!burst_done && tx_valid) tx_load = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      bit_cnt      <= '0;
      burst_cnt    <= '0;
      frame_done   <= 1'b0;
      bursting     <= 1'b0;
      burst_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_nxt == IDLE) begin
        bit_cnt    <= '0;
        burst_cnt  <= '0;
        frame_done <= 1'b0;
        bursting   <= 1'b0;
        burst_done <= 1'b0;
      end else if (state == CHK_CMD) begin
        rx_sh   <= {{DATA_W{1'b0}}, mosi};
        bit_cnt <= CNT_W'(DATA_W);
      end else begin
        if (shift_en) begin
          rx_sh <= {rx_sh[DATA_W-1:0], mosi};
          if (last_bit) begin
            rx_data    <= {rx_sh, mosi};
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        if (tx_load) begin
          tx_sh     <= tx_data;
          burst_cnt <= CNT_W'(DATA_W);
          bursting  <= 1'b1;
        end
        if (bursting) begin
          tx_sh     <= {tx_sh[DATA_W-2:0], 1'b0};
          burst_cnt <= burst_cnt - 1'b1;
          if (burst_end) begin
            bursting     <= 1'b0;
            burst_done   <= 1'b1;
            rd_addr_seen <= 1'b0;
          end
        end
      end
    end
  end

  assign miso = bursting & tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed vector table, reset corner case,
// then random frames checked against a frame-level reference model.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] held_rx;

  spi_slave_ctrl #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frame;
    int         abort_at;
    logic       burst;
    logic [7:0] txb;
    int         tx_delay;
    logic [9:0] exp_rx;
    logic       exp_seen;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one frame (optionally aborted after abort_at sampled bits) and check everything around it.
  task automatic do_frame(input logic [9:0] frame, input int abort_at, input logic burst,
                          input logic [7:0] txb, input int tx_delay,
                          input logic [9:0] exp_rx, input logic exp_seen);
    ss_n = 1'b0;
    tx_valid = 1'b0;
    step();
    check("entry_valid", rx_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) begin
        ss_n = 1'b1;
        step();
        check("abort_valid", rx_valid, 1'b0);
        check("abort_rx", rx_data, exp_rx);
        check("abort_miso", miso, 1'b0);
        check("abort_seen", dut.rd_addr_seen, exp_seen);
        step();
        check("abort_idle_valid", rx_valid, 1'b0);
        held_rx = exp_rx;
        return;
      end
      mosi     = frame[9-i];
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      step();
      if (i < 9) begin
        check("shift_valid", rx_valid, 1'b0);
        check("shift_rx_hold", rx_data, held_rx);
      end
    end
    check("done_valid", rx_valid, 1'b1);
    check("done_rx", rx_data, exp_rx);
    held_rx  = exp_rx;
    tx_valid = 1'b0;
    if (burst) begin
      for (int k = 0; k < tx_delay; k++) begin
        step();
        if (k == 0) check("valid_one_cycle", rx_valid, 1'b0);
        check("wait_miso", miso, 1'b0);
      end
      tx_valid = 1'b1;
      tx_data  = txb;
      step();
      tx_valid = 1'b0;
      tx_data  = ~txb;
      for (int b = 7; b >= 0; b--) begin
        check("burst_miso", miso, txb[b]);
        mosi     = 1'($urandom);
        tx_valid = (b == 0) ? 1'b0 : 1'($urandom);
        step();
      end
      tx_valid = 1'b0;
      check("post_burst_miso", miso, 1'b0);
      step();
      check("post_burst_miso2", miso, 1'b0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        mosi     = 1'($urandom);
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        step();
        if (k == 0) check("valid_one_cycle", rx_valid, 1'b0);
        check("park_miso", miso, 1'b0);
        check("park_rx_hold", rx_data, held_rx);
      end
      tx_valid = 1'b0;
    end
    check("seen_after", dut.rd_addr_seen, exp_seen);
    ss_n = 1'b1;
    step();
    check("release_miso", miso, 1'b0);
    step();
  endtask

  initial begin
    logic [9:0] m_rx;
    logic       m_seen;
    logic [9:0] fr;
    logic [9:0] rd_frame;
    int         ab;
    logic       is_rd;
    logic       is_ra;

    vecs[0] = '{10'h03A, -1, 1'b0, 8'h00, 0, 10'h03A, 1'b0};
    vecs[1] = '{10'h1C5, -1, 1'b0, 8'h00, 0, 10'h1C5, 1'b0};
    vecs[2] = '{10'h23A, -1, 1'b0, 8'h00, 0, 10'h23A, 1'b1};
    vecs[3] = '{10'h300, -1, 1'b1, 8'hC5, 1, 10'h300, 1'b0};
    vecs[4] = '{10'h0FF,  5, 1'b0, 8'h00, 0, 10'h300, 1'b0};
    vecs[5] = '{10'h255, -1, 1'b0, 8'h00, 0, 10'h255, 1'b1};
    vecs[6] = '{10'h2AA, -1, 1'b1, 8'h3C, 2, 10'h2AA, 1'b0};
    vecs[7] = '{10'h100,  9, 1'b0, 8'h00, 0, 10'h2AA, 1'b0};
    vecs[8] = '{10'h3FF,  0, 1'b0, 8'h00, 0, 10'h2AA, 1'b0};

    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    held_rx  = 10'h000;
    #12;
    check("reset_rx", rx_data, 10'h000);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_miso", miso, 1'b0);
    check("reset_seen", dut.rd_addr_seen, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_valid", rx_valid, 1'b0);

    foreach (vecs[i])
      do_frame(vecs[i].frame, vecs[i].abort_at, vecs[i].burst, vecs[i].txb,
               vecs[i].tx_delay, vecs[i].exp_rx, vecs[i].exp_seen);

    // Reset pulse in the middle of a miso burst
    do_frame(10'h23A, -1, 1'b0, 8'h00, 0, 10'h23A, 1'b1);
    rd_frame = 10'h300;
    ss_n = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      mosi = rd_frame[9-i];
      step();
    end
    check("rst_seq_rx", rx_data, 10'h300);
    step();
    tx_valid = 1'b1;
    tx_data  = 8'hC5;
    step();
    tx_valid = 1'b0;
    check("rst_seq_bit7", miso, 1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", miso, 1'b0);
    check("rst_mid_rx", rx_data, 10'h000);
    check("rst_mid_valid", rx_valid, 1'b0);
    check("rst_mid_seen", dut.rd_addr_seen, 1'b0);
    ss_n = 1'b1;
    #3;
    rst_n = 1'b1;
    held_rx = 10'h000;
    step();
    step();
    check("post_rst_idle_valid", rx_valid, 1'b0);
    check("post_rst_idle_miso", miso, 1'b0);
    do_frame(10'h377, -1, 1'b0, 8'h00, 0, 10'h377, 1'b1);

    // Random frames against a frame-level model of routing and rd_addr_seen
    m_rx   = held_rx;
    m_seen = 1'b1;
    for (int n = 0; n < 40; n++) begin
      fr    = 10'($urandom);
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      is_rd = fr[9] && m_seen;
      is_ra = fr[9] && !m_seen;
      if (ab < 0) begin
        m_rx = fr;
        if (is_ra) m_seen = 1'b1;
        if (is_rd) m_seen = 1'b0;
      end
      do_frame(fr, ab, is_rd && (ab < 0), 8'($urandom), int'($urandom_range(1, 3)), m_rx, m_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001: Parameter DATA_W, default 8: memory data/address width; frame length is DATA_W+2 bits.
REQ-002: clk  input  1  system clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: ss_n  input  1  SPI slave select, active-low, synchronous to clk.
REQ-005: mosi  input  1  serial data in, sampled on clk rising edge while ss_n=0.
REQ-006: miso  output  1  serial read data out, MSB first.
REQ-007: rx_data  output  DATA_W+2  completed frame to memory; bits [DATA_W+1:DATA_W] are the command, bits [DATA_W-1:0] are the payload.
REQ-008: rx_valid  output  1  one-cycle strobe marking a completed frame on rx_data.
REQ-009: tx_data  input  DATA_W  read data from memory.
REQ-010: tx_valid  input  1  tx_data is valid this cycle.

Function
REQ-011: FSM SHALL have exactly five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012: IDLE -> CHK_CMD when ss_n=0; otherwise remain in IDLE.
REQ-013: In CHK_CMD, the sampled mosi SHALL be frame bit DATA_W+1 (MSB); mosi=0 -> WRITE; mosi=1 and rd_addr_seen=0 -> READ_ADD; mosi=1 and rd_addr_seen=1 -> READ_DATA.
REQ-014: In WRITE, READ_ADD and READ_DATA, the block SHALL shift in the remaining DATA_W+1 bits MSB first, one per cycle, counted by a bit counter.
REQ-015: On the cycle the last frame bit is sampled, rx_data SHALL load the full frame; rx_valid SHALL be 1 on the next cycle only.
REQ-016: rx_data SHALL change only on frame completion; it SHALL hold between frames, with no partial shifting visible.
REQ-017: Command bits are forwarded unchanged; routing depends only on frame MSB and rd_addr_seen.
REQ-018: rd_addr_seen SHALL set on completion of a READ_ADD frame and clear on completion of a READ_DATA miso burst.
REQ-019: After frame completion in WRITE or READ_ADD, the FSM SHALL ignore mosi and remain in that state until ss_n=1.
REQ-020: In READ_DATA, after rx_valid the block SHALL wait for tx_valid=1 and latch tx_data into a shift register on that cycle.
REQ-021: Starting the cycle after the latch, miso SHALL present latched bits DATA_W-1..0, one per cycle, for DATA_W cycles; miso=0 at all other times.
REQ-022: tx_valid outside the READ_DATA wait window SHALL be ignored.
REQ-023: ss_n=1 in any non-IDLE state SHALL force IDLE next cycle and clear the bit counter.
REQ-024: On that abort, a partial frame SHALL be discarded: no rx_valid, rx_data unchanged, rd_addr_seen unchanged, miso=0.
REQ-025: Only one frame is accepted per ss_n low period.

Reset
REQ-026: rst_n=0 SHALL asynchronously set state=IDLE, rx_data=0, rx_valid=0, miso=0, rd_addr_seen=0, bit counter=0, shift register=0.
REQ-027: Reset asserted mid-frame or mid-burst SHALL abandon it; after release the FSM SHALL wait in IDLE for ss_n=0.

Verification
REQ-028: Write-address frame 00_0x3A, then frame 01_0xC5 -> rx_valid one cycle after the 10th bit; rx_data=0x03A then 0x1C5.
REQ-029: Read-address frame 10_0x3A -> rx_data=0x23A; rd_addr_seen=1; next frame with MSB=1 routes to READ_DATA.
REQ-030: Read-data frame 11_0x00 with tx_valid=1, tx_data=0xC5 one cycle after rx_valid -> miso=1,1,0,0,0,1,0,1 on the next 8 cycles; rd_addr_seen=0 afterwards.
REQ-031: ss_n raised after 5 bits of a WRITE frame -> IDLE next cycle; no rx_valid; rx_data holds the previous value.
REQ-032: rst_n pulsed low during a miso burst -> miso=0 immediately; state=IDLE; rd_addr_seen=0; next frame with MSB=1 routes to READ_ADD.
REQ-033: tx_valid=1 while in WRITE -> no miso activity; miso stays 0.
